// File: rtl/accumulator_bank.sv
// accumulator_bank: NUM_REGS x WIDTH accumulators with load/add/sub/clear through a capture/execute pipeline,
// sticky per-register overflow and optional unsigned saturation.
module accumulator_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             regWrite,
    input  logic [1:0]       op,
    input  logic [SEL_W-1:0] RegisterNumber,
    input  logic [WIDTH-1:0] writeData,
    input  logic             clearAll,
    input  logic [SEL_W-1:0] readRegister,
    output logic [WIDTH-1:0] readData,
    output logic             overflow,
    output logic             zero,
    output logic             done
);
    localparam logic [1:0]     OP_LOAD = 2'b00;
    localparam logic [1:0]     OP_ADD  = 2'b01;
    localparam logic [1:0]     OP_SUB  = 2'b10;
    localparam logic [SEL_W:0] NREGS   = (SEL_W + 1)'(NUM_REGS);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] ovf_q, ovf_d;
    logic                s1_valid_q, s1_valid_d;
    logic [1:0]          s1_op_q, s1_op_d;
    logic [SEL_W-1:0]    s1_reg_q, s1_reg_d;
    logic [WIDTH-1:0]    s1_data_q, s1_data_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    a, res;
    logic [WIDTH:0]      sum, diff;
    logic                ovf_res, rd_ok, wr_ok;

    assign a     = regs_q[s1_reg_q];
    assign sum   = {1'b0, a} + {1'b0, s1_data_q};
    assign diff  = {1'b0, a} - {1'b0, s1_data_q};
    assign wr_ok = {1'b0, RegisterNumber} < NREGS;
    assign rd_ok = {1'b0, readRegister} < NREGS;

    always_comb begin
        res = s1_op_q == OP_LOAD ? s1_data_q :
              s1_op_q == OP_ADD  ? ((sum[WIDTH] && SATURATE != 0) ? '1 : sum[WIDTH-1:0]) :
              s1_op_q == OP_SUB  ? ((diff[WIDTH] && SATURATE != 0) ? '0 : diff[WIDTH-1:0]) : '0;
        // ADD/SUB only ever set the flag; LOAD/CLR clear it
        ovf_res = (s1_op_q == OP_ADD || s1_op_q == OP_SUB) ?
                  (ovf_q[s1_reg_q] | (s1_op_q == OP_ADD ? sum[WIDTH] : diff[WIDTH])) : 1'b0;
        regs_d     = regs_q;
        ovf_d      = ovf_q;
        s1_valid_d = regWrite && wr_ok;
        s1_op_d    = op;
        s1_reg_d   = RegisterNumber;
        s1_data_d  = writeData;
        done_d     = s1_valid_q;
        if (s1_valid_q) begin
            regs_d[s1_reg_q] = res;
            ovf_d[s1_reg_q]  = ovf_res;
        end
        if (clearAll) begin
            regs_d     = '{default: '0};
            ovf_d      = '0;
            s1_valid_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q     <= '{default: '0};
            ovf_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_reg_q   <= '0;
            s1_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            ovf_q      <= ovf_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_reg_q   <= s1_reg_d;
            s1_data_q  <= s1_data_d;
            done_q     <= done_d;
        end
    end

    assign readData = rd_ok ? regs_q[readRegister] : '0;
    assign overflow = rd_ok & ovf_q[readRegister];
    assign zero     = readData == '0;
    assign done     = done_q;
endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: vector table with a writeback scoreboard on wrap and saturating banks,
// plus hand sequences for latency, clearAll, mid-flight reset and an out-of-range select.
module tb_accumulator_bank;
    localparam logic [1:0] LD = 2'd0, AD = 2'd1, SB = 2'd2, CL = 2'd3;
    localparam int NV = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, regWrite, clearAll;
    logic [1:0] op, RegisterNumber, readRegister;
    logic [7:0] writeData;
    logic [7:0] rd, rd_s, rd3;
    logic       ov, ov_s, ov3, z, z_s, z3, dn, dn_s, dn3;

    accumulator_bank dut (
        .clock(clk), .reset_n(reset_n), .regWrite(regWrite), .op(op), .RegisterNumber(RegisterNumber),
        .writeData(writeData), .clearAll(clearAll), .readRegister(readRegister),
        .readData(rd), .overflow(ov), .zero(z), .done(dn));
    accumulator_bank #(.SATURATE(1)) dut_s (
        .clock(clk), .reset_n(reset_n), .regWrite(regWrite), .op(op), .RegisterNumber(RegisterNumber),
        .writeData(writeData), .clearAll(clearAll), .readRegister(readRegister),
        .readData(rd_s), .overflow(ov_s), .zero(z_s), .done(dn_s));
    accumulator_bank #(.NUM_REGS(3)) dut3 (
        .clock(clk), .reset_n(reset_n), .regWrite(regWrite), .op(op), .RegisterNumber(RegisterNumber),
        .writeData(writeData), .clearAll(clearAll), .readRegister(readRegister),
        .readData(rd3), .overflow(ov3), .zero(z3), .done(dn3));

    typedef struct {
        logic [1:0] op;
        logic [1:0] r;
        logic [7:0] d;
        logic [7:0] e;
        logic       eo;
        logic [7:0] es;
        logic       eos;
    } vec_t;
    typedef struct {
        logic [1:0] r;
        logic [7:0] e;
        logic       eo;
        logic [7:0] es;
        logic       eos;
    } exp_t;

    vec_t vec [NV];
    exp_t sbq [$];
    exp_t x;
    int   errors = 0, checks = 0;
    logic saw, saw3;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] o, input logic [1:0] r, input logic [7:0] d);
        regWrite = w;
        op = o;
        RegisterNumber = r;
        writeData = d;
    endtask

    initial begin
        // {op, reg, data, wrap result, wrap ovf, sat result, sat ovf}; issued back to back
        vec = '{
            '{LD, 2'd1, 8'd3,   8'd3,   1'b0, 8'd3,   1'b0},
            '{LD, 2'd2, 8'd250, 8'd250, 1'b0, 8'd250, 1'b0},
            '{AD, 2'd2, 8'd10,  8'd4,   1'b1, 8'd255, 1'b1},
            '{LD, 2'd2, 8'd7,   8'd7,   1'b0, 8'd7,   1'b0},
            '{AD, 2'd0, 8'd5,   8'd5,   1'b0, 8'd5,   1'b0},
            '{AD, 2'd0, 8'd5,   8'd10,  1'b0, 8'd10,  1'b0},
            '{AD, 2'd0, 8'd5,   8'd15,  1'b0, 8'd15,  1'b0},
            '{LD, 2'd3, 8'd2,   8'd2,   1'b0, 8'd2,   1'b0},
            '{SB, 2'd3, 8'd5,   8'd253, 1'b1, 8'd0,   1'b1},
            '{AD, 2'd3, 8'd1,   8'd254, 1'b1, 8'd1,   1'b1},
            '{SB, 2'd1, 8'd3,   8'd0,   1'b0, 8'd0,   1'b0},
            '{CL, 2'd0, 8'd0,   8'd0,   1'b0, 8'd0,   1'b0},
            '{AD, 2'd1, 8'd255, 8'd255, 1'b0, 8'd255, 1'b0},
            '{AD, 2'd1, 8'd1,   8'd0,   1'b1, 8'd255, 1'b1},
            '{CL, 2'd1, 8'd0,   8'd0,   1'b0, 8'd0,   1'b0},
            '{AD, 2'd2, 8'd248, 8'd255, 1'b0, 8'd255, 1'b0}
        };
        reset_n = 1'b0;
        clearAll = 1'b0;
        readRegister = 2'd1;
        drive(1'b0, LD, 2'd0, 8'd0);
        repeat (2) @(negedge clk);
        chk("reset_rd", rd, 0);
        chk("reset_ovf", ov, 0);
        chk("reset_zero", z, 1);
        chk("reset_done", dn, 0);
        reset_n = 1'b1;

        @(negedge clk);
        drive(1'b1, LD, 2'd1, 8'd3);
        @(posedge clk); #1;
        drive(1'b0, LD, 2'd0, 8'd0);
        chk("lat_rd_e1", rd, 0);
        chk("lat_done_e1", dn, 0);
        @(posedge clk); #1;
        chk("lat_rd_e2", rd, 3);
        chk("lat_done_e2", dn, 1);
        @(posedge clk); #1;
        chk("lat_done_e3", dn, 0);

        for (int i = 0; i < NV + 3; i++) begin
            @(negedge clk);
            if (dn) begin
                if (sbq.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    x = sbq.pop_front();
                    readRegister = x.r;
                    #1;
                    chk($sformatf("v_rd[%0d]", i - 2), rd, x.e);
                    chk($sformatf("v_ovf[%0d]", i - 2), ov, x.eo);
                    chk($sformatf("v_zero[%0d]", i - 2), z, x.e == 0);
                    chk($sformatf("v_rd_sat[%0d]", i - 2), rd_s, x.es);
                    chk($sformatf("v_ovf_sat[%0d]", i - 2), ov_s, x.eos);
                    chk($sformatf("v_zero_sat[%0d]", i - 2), z_s, x.es == 0);
                    chk($sformatf("v_done_sat[%0d]", i - 2), dn_s, 1);
                end
            end
            if (i < NV) begin
                drive(1'b1, vec[i].op, vec[i].r, vec[i].d);
                sbq.push_back('{vec[i].r, vec[i].e, vec[i].eo, vec[i].es, vec[i].eos});
            end else drive(1'b0, LD, 2'd0, 8'd0);
        end
        chk("sb_empty", sbq.size(), 0);

        @(negedge clk);
        readRegister = 2'd3;
        #1;
        chk("pre_clr_ovf", ov, 1);
        chk("pre_clr_rd", rd, 254);
        drive(1'b1, AD, 2'd2, 8'd1);
        @(negedge clk);
        drive(1'b1, LD, 2'd0, 8'd99);
        clearAll = 1'b1;
        @(negedge clk);
        drive(1'b0, LD, 2'd0, 8'd0);
        clearAll = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | dn | dn_s;
        end
        chk("clr_no_done", saw, 0);
        for (int r = 0; r < 4; r++) begin
            readRegister = 2'(r);
            #1;
            chk($sformatf("clr_rd[%0d]", r), rd, 0);
            chk($sformatf("clr_ovf[%0d]", r), ov, 0);
            chk($sformatf("clr_rd_sat[%0d]", r), rd_s, 0);
            chk($sformatf("clr_ovf_sat[%0d]", r), ov_s, 0);
        end

        @(negedge clk);
        readRegister = 2'd1;
        drive(1'b1, LD, 2'd1, 8'd5);
        @(negedge clk);
        drive(1'b0, LD, 2'd0, 8'd0);
        @(negedge clk);
        chk("rst_pre_rd", rd, 5);
        drive(1'b1, AD, 2'd1, 8'd3);
        @(posedge clk);
        drive(1'b0, LD, 2'd0, 8'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_rd", rd, 0);
        chk("rst_async_zero", z, 1);
        chk("rst_async_ovf", ov, 0);
        @(negedge clk);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | dn;
        end
        chk("rst_no_done", saw, 0);
        chk("rst_rd_after", rd, 0);

        @(negedge clk);
        readRegister = 2'd3;
        drive(1'b1, LD, 2'd3, 8'd9);
        @(negedge clk);
        drive(1'b0, LD, 2'd0, 8'd0);
        saw = 1'b0;
        saw3 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | dn;
            saw3 = saw3 | dn3;
        end
        chk("n3_no_done", saw3, 0);
        chk("n3_ref_done", saw, 1);
        chk("n3_oor_rd", rd3, 0);
        chk("n3_oor_zero", z3, 1);
        chk("n4_rd3", rd, 9);
        readRegister = 2'd2;
        #1;
        chk("n3_r2_untouched", rd3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
